// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then
// shifts one byte plus odd parity out on device-generated clock falls.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_XFER,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    edge_cnt_q, edge_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d;
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          fall;
    logic [3:0]    bit_idx;

    // Synchronisers idle high so the first cycles after reset never show a fall.
    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            dat_s1_q   <= ps2_data_in;
            dat_s2_q   <= dat_s1_q;
        end
    end

    assign fall = clk_prev_q & ~clk_s2_q;

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            edge_cnt_q <= '0;
            byte_q     <= '0;
            par_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        edge_cnt_d = edge_cnt_q;
        byte_d     = byte_q;
        par_d      = par_q;

        case (state_q)
            S_IDLE: begin
                cnt_d      = '0;
                edge_cnt_d = '0;
                if (tx_valid) begin
                    byte_d  = tx_data;
                    par_d   = ~^tx_data;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d      = '0;
                    edge_cnt_d = '0;
                    state_d    = S_XFER;
                end
            end
            S_XFER: begin
                // Timeout wins over a fall landing in the same cycle.
                if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else if (fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    if (edge_cnt_q == 4'd10) begin
                        state_d = dat_s2_q ? S_ERR : S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end else if (clk_s2_q && dat_s2_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so the pins never glitch on decode.
    always_comb begin
        bit_idx   = edge_cnt_d - 4'd1;
        clk_oe_d  = (state_d == S_INHIBIT) || (state_d == S_REQ);
        data_oe_d = 1'b0;
        if (state_d == S_REQ) begin
            data_oe_d = 1'b1;
        end else if (state_d == S_XFER) begin
            if (state_q != S_XFER) begin
                data_oe_d = 1'b1;
            end else if (fall) begin
                if (edge_cnt_d >= 4'd1 && edge_cnt_d <= 4'd8) begin
                    data_oe_d = ~byte_q[bit_idx[2:0]];
                end else if (edge_cnt_d == 4'd9) begin
                    data_oe_d = ~par_q;
                end else begin
                    data_oe_d = 1'b0;
                end
            end else begin
                data_oe_d = data_oe_q;
            end
        end
        ready_d = (state_d == S_IDLE);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
    end

    assign tx_ready    = ready_q;
    assign busy        = ~ready_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural keyboard drives the shared
// open-drain lines, samples the frame on rising clock edges and optionally ACKs.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int SET  = 10;
    localparam int TO   = 3000;
    localparam int HALF = 40;

    logic       clk_50MHz = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_err;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int total = 0;
    int bad = 0;
    int n_done = 0;
    int n_err = 0;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES(SET),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .tx_done(tx_done),
        .tx_err(tx_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(negedge clk_50MHz) begin
        if (!rst) begin
            if (tx_done) n_done++;
            if (tx_err) n_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic send(input logic [7:0] d);
        int k;
        k = 0;
        @(negedge clk_50MHz);
        while (!tx_ready && k < 5000) begin
            @(negedge clk_50MHz);
            k++;
        end
        chk("send_ready", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk_50MHz);
        #1 tx_valid = 1'b0;
    endtask

    // Keyboard side: waits for the request-to-send, then clocks nfall falls.
    task automatic dev_frame(input logic ack, input int nfall, output logic [10:0] bits);
        int k;
        k = 0;
        bits = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && k < 1000) begin
            @(negedge clk_50MHz);
            k++;
        end
        chk("dev_req_seen", (k < 1000) ? 32'd1 : 32'd0, 32'd1);
        bits[0] = ps2_data_in;
        for (int e = 1; e <= nfall; e++) begin
            cyc(HALF);
            if (e == 11 && ack) dev_data = 1'b0;
            dev_clk = 1'b0;
            cyc(HALF);
            dev_clk = 1'b1;
            if (e <= 10) bits[e] = ps2_data_in;
        end
        if (nfall == 11) begin
            cyc(HALF);
            dev_data = 1'b1;
        end
    endtask

    initial begin
        logic [10:0] bits, b1, b2;
        int d0, e0, n, fd, c, k;

        // Reset state
        cyc(3);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_err", 32'(tx_err), 32'd0);
        rst = 1'b0;
        cyc(2);

        // 1: 0xED with ACK
        d0 = n_done; e0 = n_err;
        fork
            send(8'hED);
            dev_frame(1'b1, 11, bits);
        join
        chk("t1_bits", 32'(bits), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
        cyc(10);
        chk("t1_done_cnt", 32'(n_done - d0), 32'd1);
        chk("t1_err_cnt", 32'(n_err - e0), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // 2: back-to-back 0x00, 0x01 with tx_valid held
        d0 = n_done; e0 = n_err;
        fork
            begin
                @(negedge clk_50MHz);
                tx_data  = 8'h00;
                tx_valid = 1'b1;
                @(posedge clk_50MHz);
                #1 tx_data = 8'h01;
                k = 0;
                while (!tx_done && k < 5000) begin
                    @(negedge clk_50MHz);
                    k++;
                end
                chk("t2_first_done_seen", (k < 5000) ? 32'd1 : 32'd0, 32'd1);
                @(negedge clk_50MHz);
                chk("t2_gap_ready", 32'(tx_ready), 32'd1);
                @(posedge clk_50MHz);
                #1 tx_valid = 1'b0;
                @(negedge clk_50MHz);
                chk("t2_second_ready", 32'(tx_ready), 32'd0);
                chk("t2_second_busy", 32'(busy), 32'd1);
            end
            begin
                dev_frame(1'b1, 11, b1);
                chk("t2_bits0", 32'(b1), 32'({1'b1, 1'b1, 8'h00, 1'b0}));
                dev_frame(1'b1, 11, b2);
                chk("t2_bits1", 32'(b2), 32'({1'b1, 1'b0, 8'h01, 1'b0}));
            end
        join
        cyc(10);
        chk("t2_done_cnt", 32'(n_done - d0), 32'd2);
        chk("t2_err_cnt", 32'(n_err - e0), 32'd0);

        // 3 + 5: request timing, then a silent device forces the timeout
        d0 = n_done; e0 = n_err;
        send(8'h5A);
        @(negedge clk_50MHz);
        n = 0;
        fd = -1;
        while (ps2_clk_oe && n < 1000) begin
            if (ps2_data_oe && fd < 0) fd = n;
            n++;
            @(negedge clk_50MHz);
        end
        chk("t3_clk_oe_len", 32'(n), 32'(INH + SET));
        chk("t3_data_oe_rise", 32'(fd), 32'(INH));
        c = 0;
        while (!tx_err && c < TO + 100) begin
            @(negedge clk_50MHz);
            c++;
        end
        chk("t5_timeout_cycles", 32'(c), 32'(TO));
        chk("t5_clk_released", 32'(ps2_clk_oe), 32'd0);
        chk("t5_data_released", 32'(ps2_data_oe), 32'd0);
        cyc(3);
        chk("t5_err_cnt", 32'(n_err - e0), 32'd1);
        chk("t5_done_cnt", 32'(n_done - d0), 32'd0);
        chk("t5_ready", 32'(tx_ready), 32'd1);

        // 4: no ACK at edge 11
        d0 = n_done; e0 = n_err;
        fork
            send(8'h3C);
            dev_frame(1'b0, 11, bits);
        join
        chk("t4_bits", 32'(bits), 32'({1'b1, 1'b1, 8'h3C, 1'b0}));
        cyc(10);
        chk("t4_err_cnt", 32'(n_err - e0), 32'd1);
        chk("t4_done_cnt", 32'(n_done - d0), 32'd0);

        // 6: reset after the fifth fall of 0xA5 (bit 4 is 0, so data is pulled low)
        d0 = n_done; e0 = n_err;
        fork
            send(8'hA5);
            dev_frame(1'b0, 4, bits);
        join
        cyc(HALF);
        dev_clk = 1'b0;
        cyc(6);
        chk("t6_pre_data_oe", 32'(ps2_data_oe), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("t6_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("t6_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("t6_ready", 32'(tx_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        @(negedge clk_50MHz);
        rst = 1'b0;
        cyc(HALF);
        dev_clk = 1'b1;
        cyc(10);
        chk("t6_no_err", 32'(n_err - e0), 32'd0);
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        fork
            send(8'h12);
            dev_frame(1'b1, 11, bits);
        join
        chk("t6_next_bits", 32'(bits), 32'({1'b1, 1'b1, 8'h12, 1'b0}));
        cyc(10);
        chk("t6_next_done", 32'(n_done - d0), 32'd1);
        chk("t6_next_err", 32'(n_err - e0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
